// File: rtl/csa14_arbiter_if.sv
// Request/response bundle for the two clients of the shared 14-bit adder.
// The arbiter takes the slave side; client logic or a bench takes the master side.
interface csa14_arbiter_if #(parameter int WIDTH = 14);
  logic             r0_valid;
  logic             r0_ready;
  logic [WIDTH-1:0] r0_a;
  logic [WIDTH-1:0] r0_b;
  logic             r0_cin;
  logic             r0_chain;
  logic             r0_rsp_valid;
  logic             r0_rsp_ready;
  logic [WIDTH-1:0] r0_sum;
  logic             r0_cout;

  logic             r1_valid;
  logic             r1_ready;
  logic [WIDTH-1:0] r1_a;
  logic [WIDTH-1:0] r1_b;
  logic             r1_cin;
  logic             r1_chain;
  logic             r1_rsp_valid;
  logic             r1_rsp_ready;
  logic [WIDTH-1:0] r1_sum;
  logic             r1_cout;

  logic             gnt_last;

  modport slave (
    input  r0_valid, r0_a, r0_b, r0_cin, r0_chain, r0_rsp_ready,
    input  r1_valid, r1_a, r1_b, r1_cin, r1_chain, r1_rsp_ready,
    output r0_ready, r0_rsp_valid, r0_sum, r0_cout,
    output r1_ready, r1_rsp_valid, r1_sum, r1_cout,
    output gnt_last
  );

  modport master (
    output r0_valid, r0_a, r0_b, r0_cin, r0_chain, r0_rsp_ready,
    output r1_valid, r1_a, r1_b, r1_cin, r1_chain, r1_rsp_ready,
    input  r0_ready, r0_rsp_valid, r0_sum, r0_cout,
    input  r1_ready, r1_rsp_valid, r1_sum, r1_cout,
    input  gnt_last
  );
endinterface

// File: rtl/csa14_arbiter.sv
// Round-robin arbiter sharing one square-root carry-select adder between two
// requesters, with per-requester response buffers and chain carries.

module csa14_rca #(parameter int W = 2) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[W];
  end
endmodule

module csa14_select_block #(parameter int W = 3) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W-1:0] sum_c0;
  logic [W-1:0] sum_c1;
  logic         cout_c0;
  logic         cout_c1;

  // Both carry hypotheses are computed up front; the incoming carry only picks one.
  csa14_rca #(.W(W)) u_rca_c0 (.a(a), .b(b), .cin(1'b0), .sum(sum_c0), .cout(cout_c0));
  csa14_rca #(.W(W)) u_rca_c1 (.a(a), .b(b), .cin(1'b1), .sum(sum_c1), .cout(cout_c1));

  assign sum  = cin ? sum_c1  : sum_c0;
  assign cout = cin ? cout_c1 : cout_c0;
endmodule

module SQRT_CSA14bit (
  input  logic [13:0] a,
  input  logic [13:0] b,
  input  logic        cin,
  output logic [13:0] sum,
  output logic        cout
);
  logic c2;
  logic c5;
  logic c9;

  // Block sizes grow 2/3/4/5 so each select mux sees its carry roughly when its sums settle.
  csa14_rca #(.W(2)) u_blk0 (
    .a(a[1:0]), .b(b[1:0]), .cin(cin), .sum(sum[1:0]), .cout(c2)
  );
  csa14_select_block #(.W(3)) u_blk1 (
    .a(a[4:2]), .b(b[4:2]), .cin(c2), .sum(sum[4:2]), .cout(c5)
  );
  csa14_select_block #(.W(4)) u_blk2 (
    .a(a[8:5]), .b(b[8:5]), .cin(c5), .sum(sum[8:5]), .cout(c9)
  );
  csa14_select_block #(.W(5)) u_blk3 (
    .a(a[13:9]), .b(b[13:9]), .cin(c9), .sum(sum[13:9]), .cout(cout)
  );
endmodule

module csa14_arbiter #(parameter int WIDTH = 14) (
  input logic              clk,
  input logic              rst,
  csa14_arbiter_if.slave   bus
);
  logic [1:0]       req_valid;
  logic [1:0]       req_cin;
  logic [1:0]       req_chain;
  logic [1:0]       rsp_ready_in;
  logic [WIDTH-1:0] req_a [2];
  logic [WIDTH-1:0] req_b [2];

  logic [1:0]       eligible;
  logic [1:0]       grant;
  logic [1:0]       accept;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  logic [1:0]       rsp_valid_q;
  logic [1:0]       rsp_valid_d;
  logic [WIDTH-1:0] sum_q [2];
  logic [WIDTH-1:0] sum_d [2];
  logic [1:0]       cout_q;
  logic [1:0]       cout_d;
  logic [1:0]       carry_q;
  logic [1:0]       carry_d;
  logic             gnt_last_q;
  logic             gnt_last_d;

  assign req_valid    = {bus.r1_valid, bus.r0_valid};
  assign req_cin      = {bus.r1_cin, bus.r0_cin};
  assign req_chain    = {bus.r1_chain, bus.r0_chain};
  assign rsp_ready_in = {bus.r1_rsp_ready, bus.r0_rsp_ready};
  assign req_a[0]     = bus.r0_a;
  assign req_a[1]     = bus.r1_a;
  assign req_b[0]     = bus.r0_b;
  assign req_b[1]     = bus.r1_b;

  // A requester may win while its buffer drains this cycle; ties go to the one that did not win last.
  always_comb begin
    eligible = req_valid & (~rsp_valid_q | rsp_ready_in);
    grant    = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = gnt_last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    accept = grant & {2{~rst}};
  end

  always_comb begin
    if (grant[1]) begin
      add_a   = req_a[1];
      add_b   = req_b[1];
      add_cin = req_chain[1] ? carry_q[1] : req_cin[1];
    end else begin
      add_a   = req_a[0];
      add_b   = req_b[0];
      add_cin = req_chain[0] ? carry_q[0] : req_cin[0];
    end
  end

  SQRT_CSA14bit u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // An accept overrides a same-edge drain so the fresh result is never dropped.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    cout_d      = cout_q;
    carry_d     = carry_q;
    gnt_last_d  = gnt_last_q;
    for (int i = 0; i < 2; i++) begin
      sum_d[i] = sum_q[i];
      if (accept[i]) begin
        sum_d[i]       = add_sum;
        cout_d[i]      = add_cout;
        carry_d[i]     = add_cout;
        rsp_valid_d[i] = 1'b1;
        gnt_last_d     = (i == 1);
      end else if (rsp_valid_q[i] && rsp_ready_in[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      sum_q[0]    <= '0;
      sum_q[1]    <= '0;
      cout_q      <= '0;
      carry_q     <= '0;
      gnt_last_q  <= 1'b1;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      sum_q[0]    <= sum_d[0];
      sum_q[1]    <= sum_d[1];
      cout_q      <= cout_d;
      carry_q     <= carry_d;
      gnt_last_q  <= gnt_last_d;
    end
  end

  assign bus.r0_ready     = accept[0];
  assign bus.r1_ready     = accept[1];
  assign bus.r0_rsp_valid = rsp_valid_q[0];
  assign bus.r1_rsp_valid = rsp_valid_q[1];
  assign bus.r0_sum       = sum_q[0];
  assign bus.r1_sum       = sum_q[1];
  assign bus.r0_cout      = cout_q[0];
  assign bus.r1_cout      = cout_q[1];
  assign bus.gnt_last     = gnt_last_q;
endmodule

// File: tb/tb_csa14_arbiter.sv
// Bench for csa14_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of grants, buffers and chain carries.
module tb_csa14_arbiter;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  csa14_arbiter_if bus ();

  csa14_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [1:0]  v;
  logic [1:0]  cin;
  logic [1:0]  chain;
  logic [1:0]  rr;
  logic [13:0] a [2];
  logic [13:0] b [2];

  assign bus.r0_valid     = v[0];
  assign bus.r1_valid     = v[1];
  assign bus.r0_a         = a[0];
  assign bus.r1_a         = a[1];
  assign bus.r0_b         = b[0];
  assign bus.r1_b         = b[1];
  assign bus.r0_cin       = cin[0];
  assign bus.r1_cin       = cin[1];
  assign bus.r0_chain     = chain[0];
  assign bus.r1_chain     = chain[1];
  assign bus.r0_rsp_ready = rr[0];
  assign bus.r1_rsp_ready = rr[1];

  bit          m_rv    [2];
  int unsigned m_sum   [2];
  bit          m_cout  [2];
  bit          m_carry [2];
  bit          m_acc   [2];
  bit          m_gl;

  bit          hold_pending [2];
  logic [13:0] hold_a [2];
  logic [13:0] hold_b [2];
  logic [1:0]  hold_cin;
  logic [1:0]  hold_chain;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      m_rv[i]         = 1'b0;
      m_sum[i]        = 0;
      m_cout[i]       = 1'b0;
      m_carry[i]      = 1'b0;
      m_acc[i]        = 1'b0;
      hold_pending[i] = 1'b0;
    end
    m_gl = 1'b1;
  endtask

  // Grant choice straight from the rules: lone eligible wins, a tie goes to the other one than last time.
  function automatic int pickGrant();
    bit el [2];
    for (int i = 0; i < 2; i++) el[i] = v[i] && (!m_rv[i] || rr[i]);
    if (el[0] && el[1]) return m_gl ? 0 : 1;
    if (el[0]) return 0;
    if (el[1]) return 1;
    return -1;
  endfunction

  task automatic checkAllOutputs(input string phase);
    checkOutput({phase, ":r0_rsp_valid"}, 32'(bus.r0_rsp_valid), 32'(m_rv[0]));
    checkOutput({phase, ":r1_rsp_valid"}, 32'(bus.r1_rsp_valid), 32'(m_rv[1]));
    checkOutput({phase, ":r0_sum"},       32'(bus.r0_sum),       m_sum[0]);
    checkOutput({phase, ":r1_sum"},       32'(bus.r1_sum),       m_sum[1]);
    checkOutput({phase, ":r0_cout"},      32'(bus.r0_cout),      32'(m_cout[0]));
    checkOutput({phase, ":r1_cout"},      32'(bus.r1_cout),      32'(m_cout[1]));
    checkOutput({phase, ":gnt_last"},     32'(bus.gnt_last),     32'(m_gl));
  endtask

  // One clock cycle: check ready mid-cycle, then advance the model across the edge and check the result.
  task automatic applyStimulus(input string phase);
    int          g;
    int unsigned full;
    #2;
    for (int i = 0; i < 2; i++) begin
      if (hold_pending[i])
        assert (v[i] && a[i] == hold_a[i] && b[i] == hold_b[i] &&
                cin[i] == hold_cin[i] && chain[i] == hold_chain[i])
          else $error("[TB] valid rule broken for r%0d", i);
    end
    g = pickGrant();
    checkOutput({phase, ":r0_ready"}, 32'(bus.r0_ready), 32'(g == 0));
    checkOutput({phase, ":r1_ready"}, 32'(bus.r1_ready), 32'(g == 1));
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = (g == i);
      if (g == i) begin
        full       = 32'(a[i]) + 32'(b[i]) + (chain[i] ? 32'(m_carry[i]) : 32'(cin[i]));
        m_sum[i]   = full % 16384;
        m_cout[i]  = (full / 16384) != 0;
        m_carry[i] = m_cout[i];
        m_rv[i]    = 1'b1;
        m_gl       = (i == 1);
      end else if (m_rv[i] && rr[i]) begin
        m_rv[i] = 1'b0;
      end
      hold_pending[i] = v[i] && !m_acc[i];
      hold_a[i]       = a[i];
      hold_b[i]       = b[i];
      hold_cin[i]     = cin[i];
      hold_chain[i]   = chain[i];
    end
    #1;
    checkAllOutputs(phase);
  endtask

  task automatic setOp(input int i, input logic [13:0] na, input logic [13:0] nb,
                       input logic ncin, input logic nchain);
    v[i]     = 1'b1;
    a[i]     = na;
    b[i]     = nb;
    cin[i]   = ncin;
    chain[i] = nchain;
  endtask

  task automatic randOp(input int i);
    setOp(i, 14'($urandom), 14'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Let pending requests finish, then drop every valid and drain the buffers.
  task automatic settle();
    rr = 2'b11;
    repeat (3) begin
      for (int i = 0; i < 2; i++) if (m_acc[i] || !v[i]) v[i] = 1'b0;
      applyStimulus("settle");
    end
  endtask

  initial begin
    v = '0; cin = '0; chain = '0; rr = '0;
    a[0] = '0; a[1] = '0; b[0] = '0; b[1] = '0;
    rst = 1'b1;
    modelReset();
    #3;
    checkAllOutputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    setOp(0, 14'h3A14, 14'h32BF, 1'b0, 1'b0);
    rr = 2'b11;
    applyStimulus("single");
    checkOutput("single_sum", 32'(bus.r0_sum), 32'h2CD3);
    checkOutput("single_cout", 32'(bus.r0_cout), 32'h1);
    settle();

    setOp(1, 14'h3FFF, 14'h0001, 1'b0, 1'b0);
    applyStimulus("chain1");
    checkOutput("chain1_sum", 32'(bus.r1_sum), 32'h0);
    checkOutput("chain1_cout", 32'(bus.r1_cout), 32'h1);
    v[1] = 1'b0;
    setOp(0, 14'h0001, 14'h0001, 1'b1, 1'b0);
    applyStimulus("chain_mid");
    v[0] = 1'b0;
    setOp(1, 14'h0000, 14'h0000, 1'b0, 1'b1);
    applyStimulus("chain2");
    checkOutput("chain2_sum", 32'(bus.r1_sum), 32'h1);
    checkOutput("chain2_cout", 32'(bus.r1_cout), 32'h0);
    settle();

    randOp(0);
    randOp(1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus("contend");
      checkOutput("contend_order", 32'(bus.gnt_last), 32'(k % 2));
      for (int i = 0; i < 2; i++) if (m_acc[i]) randOp(i);
    end
    checkOutput("contend_end", 32'(bus.gnt_last), 32'h1);
    settle();

    v = '0;
    randOp(1);
    rr = 2'b01;
    applyStimulus("bp_load");
    randOp(1);
    for (int k = 0; k < 3; k++) begin
      randOp(0);
      applyStimulus("bp_hold");
      checkOutput("bp_r0_won", 32'(bus.gnt_last), 32'h0);
    end
    v[0] = 1'b1;
    rr = 2'b11;
    applyStimulus("bp_release");
    checkOutput("bp_r1_won", 32'(bus.gnt_last), 32'h1);
    settle();

    randOp(0);
    rr = 2'b00;
    applyStimulus("drain_load");
    randOp(0);
    rr = 2'b01;
    applyStimulus("drain_acc");
    v[0] = 1'b0;
    applyStimulus("drain_last");
    settle();

    setOp(0, 14'h3FFF, 14'h0001, 1'b0, 1'b0);
    rr = 2'b00;
    applyStimulus("rst_load");
    setOp(0, 14'h0000, 14'h0000, 1'b0, 1'b1);
    #2 rst = 1'b1;
    modelReset();
    #1;
    checkOutput("rst_r0_ready", 32'(bus.r0_ready), 32'h0);
    checkAllOutputs("rst_async");
    @(posedge clk);
    #1 rst = 1'b0;
    rr = 2'b01;
    applyStimulus("rst_chain");
    checkOutput("rst_chain_sum", 32'(bus.r0_sum), 32'h0);
    settle();

    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!v[i] || m_acc[i]) begin
          if ($urandom_range(3) != 0) randOp(i);
          else v[i] = 1'b0;
        end
        rr[i] = $urandom_range(3) != 0;
      end
      applyStimulus("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
